// File: rtl/qformat_pkg.sv
// Shared Q-format definitions: default widths, FSM state encoding and the
// round-half-up / saturate helper used by the requantizing stages.
package qformat_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 4;
  localparam int ACC_W_DEF  = 20;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] value;
    logic                         clip;
  } rs_t;

  // Half an output LSB and the clip limits, all at accumulator width plus one
  // guard bit so the rounding add can never wrap.
  localparam logic signed [ACC_W_DEF:0] RS_HALF = (ACC_W_DEF+1)'(1) <<< (FRAC_W_DEF-1);
  localparam logic signed [ACC_W_DEF:0] RS_MAX  = (ACC_W_DEF+1)'((1 << (DATA_W_DEF-1)) - 1);
  localparam logic signed [ACC_W_DEF:0] RS_MIN  = ~RS_MAX;

  // Round-half-up (add half LSB, arithmetic shift) then clip to DATA_W_DEF bits.
  function automatic rs_t round_sat(input logic signed [ACC_W_DEF-1:0] acc);
    logic signed [ACC_W_DEF:0] biased;
    logic signed [ACC_W_DEF:0] shifted;
    rs_t r;
    biased  = $signed({acc[ACC_W_DEF-1], acc}) + RS_HALF;
    shifted = biased >>> FRAC_W_DEF;
    r.clip  = 1'b0;
    r.value = shifted[DATA_W_DEF-1:0];
    if (shifted > RS_MAX) begin
      r.value = RS_MAX[DATA_W_DEF-1:0];
      r.clip  = 1'b1;
    end else if (shifted < RS_MIN) begin
      r.value = RS_MIN[DATA_W_DEF-1:0];
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qformat_round_sat.sv
// Combinational requantizer: ACC_W accumulator (2*FRAC_W fractional bits in
// the dot-product use) to DATA_W result, round-half-up then clip, with flag.
// FRAC_W must be at least 1.
module qformat_round_sat
  import qformat_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result,
  output logic                     clip
);

  if (DATA_W == DATA_W_DEF && FRAC_W == FRAC_W_DEF && ACC_W == ACC_W_DEF) begin : g_pkg
    // Default geometry: use the package helper so this stage and the
    // downstream value stage round identically.
    rs_t rs;
    always_comb rs = round_sat(acc);
    assign result = rs.value;
    assign clip   = rs.clip;
  end else begin : g_generic
    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) <<< (FRAC_W-1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    // Same round-then-clip as the package helper, at this instance's widths.
    always_comb begin
      biased  = $signed({acc[ACC_W-1], acc}) + HALF;
      shifted = biased >>> FRAC_W;
      clip    = 1'b0;
      result  = shifted[DATA_W-1:0];
      if (shifted > MAX_V) begin
        result = MAX_V[DATA_W-1:0];
        clip   = 1'b1;
      end else if (shifted < MIN_V) begin
        result = MIN_V[DATA_W-1:0];
        clip   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qformat_mac.sv
// Streaming signed Q-format dot product: accumulates LEN products at full
// precision with saturation, then rounds/clips to DATA_W and hands the result
// out on a valid/ready port.
module qformat_mac
  import qformat_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                     state_reg, state_next;
  logic signed [ACC_W-1:0]    acc_reg;
  logic [LEN_W-1:0]           count_reg;
  logic                       sticky_reg;
  logic                       out_valid_reg;
  logic signed [DATA_W-1:0]   out_data_reg;
  logic                       out_sat_reg;

  logic                       take_start;
  logic                       xfer;
  logic                       handshake;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]             sum_wide;
  logic                       acc_ovf;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [DATA_W-1:0]   round_data;
  logic                       round_clip;

  // Full-precision product, sign-extended, added with one guard bit so that
  // overflow is visible as a disagreement of the top two sum bits.
  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);
  assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};
  assign acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_next = acc_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                            : $signed(sum_wide[ACC_W-1:0]);

  qformat_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_round_sat (
    .acc    (acc_reg),
    .result (round_data),
    .clip   (round_clip)
  );

  // Next-state and per-cycle event decode; start only counts in IDLE.
  always_comb begin
    state_next = state_reg;
    take_start = 1'b0;
    xfer       = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_next = (len == '0) ? ROUND : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          xfer = 1'b1;
          if (count_reg == LEN_W'(1)) state_next = ROUND;
        end
      end
      ROUND: state_next = OUT;
      OUT: begin
        if (out_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Accumulator, remaining-pair counter and accumulator-saturation sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      count_reg  <= '0;
      sticky_reg <= 1'b0;
    end else if (take_start) begin
      acc_reg    <= '0;
      count_reg  <= len;
      sticky_reg <= 1'b0;
    end else if (xfer) begin
      acc_reg   <= acc_next;
      count_reg <= count_reg - LEN_W'(1);
      if (acc_ovf) sticky_reg <= 1'b1;
    end
  end

  // Result register: captured in ROUND, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (state_reg == ROUND) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= round_data;
      out_sat_reg   <= sticky_reg | round_clip;
    end else if (handshake) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_qformat_mac.sv
// Directed bench for qformat_mac: stimulus pushes hand-computed results into a
// scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_qformat_mac;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       sat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   hs_count = 0;
  int   pushed   = 0;

  always #5 clk = ~clk;

  qformat_mac dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic [7:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic start_dot(input int n);
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] av, input logic [7:0] bv);
    int t = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      step();
      t++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic get_result();
    out_ready = 1'b1;
    wait_out_valid();
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int n, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] d, input logic s);
    expect_result(d, s);
    start_dot(n);
    for (int i = 0; i < n; i++) send_pair(av, bv);
    get_result();
  endtask

  // Scoreboard monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      hs_count++;
      $display("result %0d data=0x%02h sat=%0b", hs_count, out_data, out_sat);
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  initial begin : stim
    int hs_before;
    reset     = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    step();

    // Unity with latency: start edge, pair edge, then ROUND -> OUT edge.
    expect_result(8'h10, 1'b0);
    start_dot(1);
    check("unity_in_ready", 32'(in_ready), 32'd1);
    send_pair(8'h10, 8'h10);
    check("unity_lat_round", 32'(out_valid), 32'd0);
    step();
    check("unity_lat_out", 32'(out_valid), 32'd1);
    get_result();

    // Sign and rounding.
    run_vec(1, 8'hF0, 8'h10, 8'hF0, 1'b0);
    run_vec(1, 8'h01, 8'h08, 8'h01, 1'b0);
    run_vec(1, 8'hFF, 8'h08, 8'h00, 1'b0);

    // Output clipping, both directions.
    run_vec(4, 8'h20, 8'h20, 8'h7F, 1'b1);
    run_vec(4, 8'hE0, 8'h20, 8'h80, 1'b1);

    // Accumulator saturation: 32 * 16384 overflows 20 bits exactly once.
    run_vec(32, 8'h80, 8'h80, 8'h7F, 1'b1);

    // len = 0.
    run_vec(0, 8'h00, 8'h00, 8'h00, 1'b0);

    // Stalls and backpressure: 0.25 * 3 -> 0x0C.
    expect_result(8'h0C, 1'b0);
    start_dot(3);
    a = 8'h08;
    b = 8'h08;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 0 || i == 3 || i == 5);
      step();
    end
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h0C);
      step();
    end
    hs_before = hs_count;
    get_result();
    check("stall_one_xfer", 32'(hs_count - hs_before), 32'd1);
    check("stall_valid_drop", 32'(out_valid), 32'd0);
    step();
    check("stall_idle", 32'(busy), 32'd0);

    // start pulsed during ACCUM is ignored: 1.0 + 0.5 -> 0x18.
    expect_result(8'h18, 1'b0);
    start_dot(2);
    send_pair(8'h10, 8'h10);
    start = 1'b1;
    len   = 8'd5;
    step();
    start = 1'b0;
    check("ign_start_busy", 32'(busy), 32'd1);
    send_pair(8'h08, 8'h10);
    get_result();

    // Handshake with start high in the same cycle: start not taken.
    expect_result(8'h01, 1'b0);
    start_dot(1);
    send_pair(8'h01, 8'h08);
    wait_out_valid();
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    check("hs_start_idle", 32'(busy), 32'd0);
    step();
    check("hs_start_still_idle", 32'(busy), 32'd0);

    // Reset mid-ACCUM after 2 of 4 pairs, then a fresh run: 1.0 * 2.0 -> 0x20.
    start_dot(4);
    send_pair(8'h10, 8'h10);
    send_pair(8'h10, 8'h10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    run_vec(1, 8'h10, 8'h20, 8'h20, 1'b0);

    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("hs_total", 32'(hs_count), 32'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
